// File: rtl/apb_pkg.sv
// Shared APB defaults and the scheduler FSM state encoding.
package apb_pkg;

  localparam int APB_ADDR_WIDTH = 8;
  localparam int APB_DATA_WIDTH = 24;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd1,
    ST_SETUP  = 2'd3,
    ST_ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_write_scheduler_rr_arbiter.sv
// Combinational round-robin pick: searches from rr_ptr+1 upward, wrapping to 0.
module rr_arbiter #(
  parameter int NUM_REQ = 8
) (
  input  logic [NUM_REQ-1:0]         eligible,
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
  output logic [$clog2(NUM_REQ)-1:0] winner,
  output logic                       valid
);

  localparam int IDW = $clog2(NUM_REQ);

  logic [IDW-1:0] idx;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    // k = NUM_REQ revisits rr_ptr itself last, so the previous winner has lowest priority
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IDW'((int'(rr_ptr) + k) % NUM_REQ);
      if (!valid && eligible[idx]) begin
        valid  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/apb_write_scheduler.sv
// Shares one APB3 master port among NUM_REQ write requesters, round-robin,
// with a per-transfer ACCESS timeout that completes the transfer with err=1.
module apb_write_scheduler
  import apb_pkg::*;
#(
  parameter int NUM_REQ    = 8,
  parameter int ADDR_WIDTH = APB_ADDR_WIDTH,
  parameter int DATA_WIDTH = APB_DATA_WIDTH,
  parameter int TIMEOUT    = 16
) (
  input  logic                          pclk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            ack,
  output logic [NUM_REQ-1:0]            err,
  output logic                          psel,
  output logic                          penable,
  output logic                          pwrite,
  output logic [ADDR_WIDTH-1:0]         paddr,
  output logic [DATA_WIDTH-1:0]         pwdata,
  input  logic                          pready,
  input  logic                          pslverr,
  output logic                          busy,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output apb_state_e                    dbg_state
);

  localparam int IDW = $clog2(NUM_REQ);

  // Requester handshake: req is a level held until ack; ack/err pulse for one
  // cycle, and a req still high the cycle after its ack is a new request.
  apb_state_e             state, state_d;
  logic [7:0]             wait_cnt, wait_d;
  logic [IDW-1:0]         rr_ptr, rr_d, grant_d, win;
  logic                   win_valid;
  logic                   psel_d, penable_d;
  logic [ADDR_WIDTH-1:0]  paddr_d;
  logic [DATA_WIDTH-1:0]  pwdata_d;
  logic [NUM_REQ-1:0]     ack_d, err_d;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .eligible (req & ~ack),
    .rr_ptr   (rr_ptr),
    .winner   (win),
    .valid    (win_valid)
  );

  assign pwrite    = 1'b1;
  assign dbg_state = state;

  always_comb begin
    state_d   = state;
    wait_d    = wait_cnt;
    rr_d      = rr_ptr;
    grant_d   = grant_id;
    psel_d    = psel;
    penable_d = penable;
    paddr_d   = paddr;
    pwdata_d  = pwdata;
    ack_d     = '0;
    err_d     = '0;
    case (state)
      ST_IDLE: begin
        if (win_valid) begin
          for (int i = 0; i < NUM_REQ; i++) begin
            if (win == IDW'(i)) begin
              paddr_d  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
              pwdata_d = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
          end
          grant_d   = win;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = ST_SETUP;
        end
      end
      ST_SETUP: begin
        penable_d = 1'b1;
        wait_d    = '0;
        state_d   = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (pready || wait_cnt == 8'(TIMEOUT - 1)) begin
          psel_d          = 1'b0;
          penable_d       = 1'b0;
          ack_d[grant_id] = 1'b1;
          err_d[grant_id] = pready ? pslverr : 1'b1;
          rr_d            = grant_id;
          state_d         = ST_IDLE;
        end else begin
          wait_d = wait_cnt + 8'd1;
        end
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      rr_ptr   <= IDW'(NUM_REQ - 1);
      grant_id <= '0;
      psel     <= 1'b0;
      penable  <= 1'b0;
      paddr    <= '0;
      pwdata   <= '0;
      ack      <= '0;
      err      <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_d;
      wait_cnt <= wait_d;
      rr_ptr   <= rr_d;
      grant_id <= grant_d;
      psel     <= psel_d;
      penable  <= penable_d;
      paddr    <= paddr_d;
      pwdata   <= pwdata_d;
      ack      <= ack_d;
      err      <= err_d;
      busy     <= (state_d == ST_SETUP) || (state_d == ST_ACCESS);
    end
  end

endmodule

// File: tb/tb_apb_write_scheduler.sv
// Directed bench for apb_write_scheduler: a vector table of single transfers
// plus hand-written sequences for fairness, chaining, stability and reset.
module tb_apb_write_scheduler;
  import apb_pkg::*;

  localparam int NR = 8;
  localparam int AW = 8;
  localparam int DW = 24;

  logic              pclk = 1'b0;
  logic              reset = 1'b1;
  logic [NR-1:0]     req = '0;
  logic [NR*AW-1:0]  req_addr = '0;
  logic [NR*DW-1:0]  req_data = '0;
  logic [NR-1:0]     ack, err;
  logic              psel, penable, pwrite, busy;
  logic [AW-1:0]     paddr;
  logic [DW-1:0]     pwdata;
  logic              pready = 1'b0;
  logic              pslverr = 1'b0;
  logic [2:0]        grant_id;
  apb_state_e        dbg_state;

  int checks = 0;
  int failures = 0;
  int cyc_cnt = 0;

  logic [AW-1:0] addr_arr [NR];
  logic [DW-1:0] data_arr [NR];

  typedef struct {
    logic [NR-1:0] rq;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            waits;   // ACCESS cycles with pready low; -1 = never ready
    logic          slverr;
    int            gid;
    logic          exp_err;
    int            access;
  } vec_t;

  vec_t tbl [6];

  apb_write_scheduler #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(16)) dut (
    .pclk(pclk), .reset(reset), .req(req), .req_addr(req_addr), .req_data(req_data),
    .ack(ack), .err(err), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pready(pready), .pslverr(pslverr),
    .busy(busy), .grant_id(grant_id), .dbg_state(dbg_state)
  );

  // Clock and reset
  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc_cnt <= cyc_cnt + 1;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard compare
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp_v);
    end
  endtask

  task automatic pack();
    for (int i = 0; i < NR; i++) begin
      req_addr[i*AW +: AW] = addr_arr[i];
      req_data[i*DW +: DW] = data_arr[i];
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req = '0;
    pready = 1'b0;
    pslverr = 1'b0;
    repeat (2) @(posedge pclk);
    #1;
    reset = 1'b0;
  endtask

  // One transfer from IDLE; end_mode 0 clears req, 1 drops the acked bit, 2 holds req.
  task automatic do_xfer(input logic [NR-1:0] rq, input int waits, input logic slverr,
                         input int exp_gid, input logic exp_err, input int exp_access,
                         input int end_mode, input string name);
    int cyc;
    int acc;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic stable;
    req = rq;
    pack();
    pready = 1'b0;
    pslverr = 1'b0;
    cyc = 0;
    do begin
      @(posedge pclk);
      #1;
      cyc++;
      if (cyc == 1) chk({name, ":ack_idle"}, 64'({ack, err}), 64'd0);
    end while (!psel && cyc < 50);
    chk({name, ":grant_lat"}, 64'(cyc), 64'd1);
    chk({name, ":setup"}, 64'({psel, penable, busy, pwrite}), 64'b1011);
    chk({name, ":grant_id"}, 64'(grant_id), 64'(exp_gid));
    chk({name, ":paddr"}, 64'(paddr), 64'(addr_arr[exp_gid]));
    chk({name, ":pwdata"}, 64'(pwdata), 64'(data_arr[exp_gid]));
    a0 = paddr;
    d0 = pwdata;
    @(posedge pclk);
    #1;
    chk({name, ":access"}, 64'({psel, penable, busy}), 64'b111);
    acc = 1;
    stable = 1'b1;
    while (psel && acc <= 40) begin
      req_addr = {$urandom, $urandom};
      req_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      pready = (waits >= 0) && (acc > waits);
      pslverr = slverr;
      @(posedge pclk);
      #1;
      if (paddr !== a0 || pwdata !== d0) stable = 1'b0;
      if (psel) acc++;
    end
    pready = 1'b0;
    pslverr = 1'b0;
    pack();
    chk({name, ":access_len"}, 64'(acc), 64'(exp_access));
    chk({name, ":ack"}, 64'(ack), 64'(NR'(1) << exp_gid));
    chk({name, ":err"}, 64'(err), exp_err ? 64'(NR'(1) << exp_gid) : 64'd0);
    chk({name, ":done"}, 64'({psel, penable, busy}), 64'd0);
    chk({name, ":stable"}, 64'(stable), 64'd1);
    if (end_mode == 0) req = '0;
    else if (end_mode == 1) req = req & ~(NR'(1) << exp_gid);
  endtask

  initial begin
    logic [NR-1:0] rem;
    int t0;

    for (int i = 0; i < NR; i++) begin
      addr_arr[i] = AW'(8'h40 + i);
      data_arr[i] = DW'(24'h5A0000 + 24'h000111 * i);
    end
    //            rq     addr   data        waits slverr gid err access
    tbl[0] = '{8'h04, 8'h3C, 24'hABCDEF,  0, 1'b0, 2, 1'b0,  1};
    tbl[1] = '{8'h24, 8'h91, 24'h123456,  5, 1'b1, 5, 1'b1,  6};
    tbl[2] = '{8'h21, 8'h07, 24'hFEDCBA,  2, 1'b0, 0, 1'b0,  3};
    tbl[3] = '{8'h81, 8'hE2, 24'h00FF00,  0, 1'b1, 7, 1'b1,  1};
    tbl[4] = '{8'h81, 8'h5D, 24'h0F0F0F, -1, 1'b0, 0, 1'b1, 16};
    tbl[5] = '{8'h03, 8'hA5, 24'h777777,  0, 1'b0, 1, 1'b0,  1};

    do_reset();
    chk("reset_outputs", 64'({psel, penable, pwrite, busy, ack, err}), 64'({4'b0010, 16'h0}));
    chk("reset_bus", 64'({paddr, pwdata, grant_id}), 64'd0);
    chk("reset_state", 64'(dbg_state), 64'(ST_IDLE));

    foreach (tbl[v]) begin
      addr_arr[tbl[v].gid] = tbl[v].addr;
      data_arr[tbl[v].gid] = tbl[v].data;
      do_xfer(tbl[v].rq, tbl[v].waits, tbl[v].slverr, tbl[v].gid, tbl[v].exp_err,
              tbl[v].access, 0, $sformatf("vec%0d", v));
    end

    // Held request is re-granted only after the other pending requester
    do_reset();
    do_xfer(8'h05, 0, 1'b0, 0, 1'b0, 1, 2, "hold_a");
    do_xfer(8'h05, 0, 1'b0, 2, 1'b0, 1, 2, "hold_b");
    do_xfer(8'h05, 0, 1'b0, 0, 1'b0, 1, 0, "hold_c");

    // All requesters: grants 0..7 back to back, one every 3 cycles
    do_reset();
    rem = 8'hFF;
    t0 = cyc_cnt;
    for (int i = 0; i < NR; i++) begin
      do_xfer(rem, 0, 1'b0, i, 1'b0, 1, 1, $sformatf("all%0d", i));
      rem = rem & ~(NR'(1) << i);
    end
    chk("all_period", 64'(cyc_cnt - t0), 64'd24);

    // Reset in ACCESS cycle 2 abandons the transfer and restores priority 0
    do_reset();
    do_xfer(8'h04, 0, 1'b0, 2, 1'b0, 1, 0, "pre_rst");
    req = 8'h81;
    @(posedge pclk);
    #1;
    chk("rst_grant7", 64'({psel, grant_id}), 64'({1'b1, 3'd7}));
    repeat (2) @(posedge pclk);
    #1;
    chk("rst_in_access", 64'({psel, penable}), 64'b11);
    reset = 1'b1;
    @(posedge pclk);
    #1;
    chk("rst_abandon", 64'({psel, penable, busy, ack, err}), 64'd0);
    reset = 1'b0;
    do_xfer(8'h81, 0, 1'b0, 0, 1'b0, 1, 0, "rst_regrant");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb_write_scheduler.md
APB_WRITE_SCHEDULER -- requirements
Module: apb_write_scheduler

Interface
REQ-001 SHALL have parameter NUM_REQ, default 8: number of requesters sharing the APB bus (2..64).
REQ-002 SHALL have parameter ADDR_WIDTH, default 8: APB address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 24: APB data width.
REQ-004 SHALL have parameter TIMEOUT, default 16: maximum ACCESS cycles per transfer (2..255).
REQ-005 SHALL have port pclk, input, 1 bit: clock; all logic on rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port req, input, NUM_REQ bits: per-requester write request, level.
REQ-008 SHALL have port req_addr, input, NUM_REQ*ADDR_WIDTH bits: packed addresses; requester i uses slice i.
REQ-009 SHALL have port req_data, input, NUM_REQ*DATA_WIDTH bits: packed write data; requester i uses slice i.
REQ-010 SHALL have port ack, output, NUM_REQ bits: one-cycle completion pulse per requester.
REQ-011 SHALL have port err, output, NUM_REQ bits: error qualifier, valid only with ack.
REQ-012 SHALL have ports psel, penable and pwrite, each output, 1 bit: APB control.
REQ-013 SHALL have ports paddr (output, ADDR_WIDTH) and pwdata (output, DATA_WIDTH): APB address and write data.
REQ-014 SHALL have ports pready and pslverr, each input, 1 bit: APB3 slave response.
REQ-015 SHALL have port busy, output, 1 bit: high while in SETUP or ACCESS.
REQ-016 SHALL have port grant_id, output, $clog2(NUM_REQ) bits: index of the current or last granted requester.

Function
REQ-017 SHALL implement FSM states IDLE, SETUP, ACCESS, with all outputs registered.
REQ-018 IDLE: the eligible set SHALL be req & ~ack; if the eligible set is nonzero, the FSM SHALL pick a winner round-robin, starting search at rr_ptr+1 and wrapping at NUM_REQ-1 -> 0.
REQ-019 On the grant edge, the block SHALL latch the winner's addr/data into paddr/pwdata, set grant_id=winner, psel=1, penable=0, and move to SETUP.
REQ-020 SETUP SHALL last exactly 1 cycle; the next edge SHALL set penable=1, clear wait_cnt to 0, and move to ACCESS.
REQ-021 ACCESS with pready=1: the next edge SHALL set psel=0, penable=0, pulse ack[grant_id]=1, set err[grant_id]=pslverr, set rr_ptr=grant_id, and move to IDLE.
REQ-022 ACCESS with pready=0 and wait_cnt<TIMEOUT-1: the FSM SHALL stay in ACCESS and increment wait_cnt.
REQ-023 ACCESS with pready=0 and wait_cnt==TIMEOUT-1: the FSM SHALL terminate as in REQ-021 but with err[grant_id]=1, so ACCESS lasts at most TIMEOUT cycles.
REQ-024 ack and err SHALL be high for exactly one cycle, the first IDLE cycle, and all other bits SHALL be 0.
REQ-025 The minimum transfer period SHALL be 3 cycles (SETUP, ACCESS, IDLE), with no back-to-back SETUP.
REQ-026 A requester SHALL drop req in the ack cycle; if req is still high in the following cycle, it SHALL be treated as a new request.
REQ-027 pwrite SHALL be constant 1; paddr/pwdata SHALL hold stable from SETUP through end of ACCESS, ignoring req_addr/req_data changes.
REQ-028 A requester dropping req after grant SHALL NOT abort the transfer; it SHALL still receive ack.
REQ-029 Simultaneous requests SHALL be resolved only by rr_ptr order; no requester SHALL wait more than NUM_REQ-1 grants.
REQ-030 busy SHALL be 1 in SETUP/ACCESS and 0 in IDLE.

Reset
REQ-031 On reset, outputs SHALL be: psel=0, penable=0, pwrite=1, paddr=0, pwdata=0, ack=0, err=0, busy=0, grant_id=0.
REQ-032 On reset, internal state SHALL be: state=IDLE, wait_cnt=0, rr_ptr=NUM_REQ-1, so requester 0 has first priority.
REQ-033 Reset during SETUP/ACCESS SHALL abandon the transfer with no ack/err issued, and psel SHALL be 0 the cycle after reset is sampled.

Structure
REQ-034 Shared package apb_pkg SHALL hold ADDR_WIDTH/DATA_WIDTH defaults and the FSM state encoding (IDLE=1, SETUP=3, ACCESS=2).
REQ-035 The design SHALL use one sub-module, rr_arbiter: combinational round-robin pick (inputs eligible vector and rr_ptr; outputs winner index and valid).

Verification
REQ-036 Single request: req=8'h04, addr=8'h3C, data=24'hABCDEF, pready=1 -> psel at grant+1, penable at +2, ack[2] pulse at +3 with err=0, rr_ptr=2.
REQ-037 All requests: req=8'hFF held, each requester dropping req on its ack -> grant order 0,1,...,7 and 8 acks in 24 cycles.
REQ-038 Wait states: pready low 5 ACCESS cycles then high with pslverr=1 -> ACCESS lasts 6 cycles; ack and err pulse together.
REQ-039 Timeout: TIMEOUT=16, pready stuck 0 -> ACCESS lasts exactly 16 cycles, then ack=err=1 for the granted requester and psel=0.
REQ-040 Reset mid-ACCESS: reset asserted on ACCESS cycle 2 -> psel=0 next cycle, no ack, and next grant goes to requester 0 despite req=8'h81.
REQ-041 Stability: req_addr changed during ACCESS -> paddr unchanged until completion; held req after ack -> re-granted only after other pending requesters.
